pmem_burst_adaptor: RTL and testbench
=====================================

// Module: pmem_burst_adaptor
// PURPOSE
//  Sits directly downstream of the I/D memory arbiter. Converts one 256-bit cacheline read/write
//  from the arbiter into a 4-beat x 64-bit burst on the physical-memory port. Read beats are
//  reassembled into a full line before one response pulse goes back to the arbiter.
//  Write lines are latched and streamed out one beat per pmem acknowledge.
// PARAMETERS
//  LINE_W   256  cacheline width (bits); must be BURST_W * BEATS
//  BURST_W  64   pmem data beat width (bits)
//  ADDR_W   32   address width (bits)
//  BEATS    4    beats per line; derived localparam LINE_W/BURST_W, not overridable
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  read_i     in   1        line read request from arbiter (held until resp_o)
//  write_i    in   1        line write request from arbiter (held until resp_o)
//  address_i  in   ADDR_W   line address from arbiter
//  line_i     in   LINE_W   write line from arbiter
//  line_o     out  LINE_W   assembled read line; valid while resp_o=1
//  resp_o     out  1        one-cycle completion pulse to arbiter
//  burst_i    in   BURST_W  read beat from pmem
//  burst_o    out  BURST_W  write beat to pmem
//  address_o  out  ADDR_W   line-aligned burst address to pmem
//  read_o     out  1        pmem burst read request
//  write_o    out  1        pmem burst write request
//  resp_i     in   1        pmem per-beat acknowledge (beat valid/accepted this cycle)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, beat count=0, line buffer=0. Outputs resp_o/read_o/write_o=0,
//   line_o/burst_o/address_o=0. Outputs drop immediately, without waiting for clk. Any in-flight
//   burst is abandoned; pmem beats arriving after reset release are ignored in IDLE.
//  FSM states: IDLE, RD_BURST, WR_BURST, DONE.
//  IDLE: write_i=1 -> latch address_i and line_i; go WR_BURST. Else read_i=1 -> latch address_i;
//   go RD_BURST. write_i and read_i both high: write wins.
//  RD_BURST: read_o=1. Each cycle with resp_i=1: buffer[cnt*64 +: 64] <= burst_i, cnt++.
//   Beat 0 = line bits [63:0]. On the acknowledge of beat BEATS-1 go DONE. resp_i=0 cycles
//   (stalls) hold cnt; no limit on stall length.
//  WR_BURST: write_o=1, burst_o = latched_line[cnt*64 +: 64]. Each resp_i=1 cycle: cnt++.
//   On the acknowledge of the last beat go DONE.
//  DONE: resp_o=1 for exactly one cycle. line_o = assembled buffer (also for writes; don't-care).
//   read_o=write_o=0. Next state is always IDLE. read_i/write_i are not sampled in DONE, so the
//   arbiter's request, still high that cycle, cannot restart a burst.
//  read_o/write_o are decoded only from the state register, never from inputs. They stay high
//   continuously from the cycle after acceptance through the last-beat cycle.
//  address_o = {latched_addr[ADDR_W-1:5], 5'b0}, constant for the whole burst. Input low bits
//   are ignored.
//  cnt: $clog2(BEATS) bits, cleared on entry to any burst; wraps to 0 on the last beat.
//  resp_i in IDLE or DONE: ignored, no state change.
//  Latency, read with zero pmem stall: request sampled at edge 0, read_o high cycles 1..4 with
//   resp_i each cycle, resp_o in cycle 5. Minimum 6 cycles request-to-response.
//  Requests dropped mid-burst by the arbiter: burst still completes. resp_o still pulses once.
//  line_o holds its value after DONE until the next read burst overwrites beats.
// STRUCTURE
//  Shared package (rv32i_types): pmem_burst_state_t enum {IDLE,RD_BURST,WR_BURST,DONE};
//   constants LINE_W=256, BURST_W=64, BEATS=4, LINE_OFFSET_BITS=5.
//  Single module, no sub-module. Three parts:
//   - state/cnt registers in one async-reset always_ff
//   - latched address/line/buffer registers
//   - combinational output decode
// TESTING
//  1 Read, no stall: addr_i=0x0000_1234, beats 0xA..A,0xB..B,0xC..C,0xD..D ->
//    address_o=0x0000_1220; line_o={D,C,B,A}; resp_o exactly one pulse in cycle 5.
//  2 Write with stalls: line_i=256'h0123..EF, resp_i pattern 1,0,0,1,1,0,1 -> burst_o steps
//    through line[63:0]..line[255:192] only on resp_i=1; write_o high throughout; 1 resp_o.
//  3 read_i=write_i=1 in IDLE -> write burst taken, read_o never asserts.
//  4 Back-to-back: request held through DONE cycle -> no new burst; next request, issued after
//    IDLE, accepted normally and cnt restarts at 0.
//  5 rst_n low after 2 read beats -> read_o=0 same cycle, state IDLE, no resp_o. A fresh read
//    after release returns a correct 4-beat line.
//  6 Spurious resp_i=1 in IDLE and in DONE -> no state change, no extra resp_o, cnt stays 0.

Source files
------------

// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// Package: rv32i_types
//
// Purpose:
//   Shared types and constants for the physical-memory side of the cache
//   hierarchy. The burst adaptor imports this to get its FSM state encoding
//   and the default cacheline / pmem beat geometry.
//
// Contents:
//   LINE_W            cacheline width in bits
//   BURST_W           pmem data beat width in bits
//   BEATS             beats per cacheline (LINE_W / BURST_W)
//   LINE_OFFSET_BITS  byte-offset bits inside one cacheline (32-byte line)
//   pmem_burst_state_t  burst adaptor FSM states
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int LINE_W           = 256;
    localparam int BURST_W          = 64;
    localparam int BEATS            = LINE_W / BURST_W;
    localparam int LINE_OFFSET_BITS = 5;

    // IDLE waits for the arbiter, the two burst states run the pmem
    // handshake, and DONE is the single cycle in which the arbiter sees resp_o.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } pmem_burst_state_t;

endpackage

// File: rtl/pmem_burst_adaptor.sv
// ----------------------------------------------------------------------------
// Module: pmem_burst_adaptor
//
// Purpose:
//   Sits directly below the I/D memory arbiter. One 256-bit cacheline read or
//   write from the arbiter becomes a 4-beat x 64-bit burst on the pmem port.
//   Read beats are reassembled into a full line before a single resp_o pulse
//   goes back; write lines are latched and streamed out one beat per pmem
//   acknowledge.
//
// Ports:
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   read_i     in   1        line read request from arbiter (held until resp_o)
//   write_i    in   1        line write request from arbiter (held until resp_o)
//   address_i  in   ADDR_W   line address from arbiter
//   line_i     in   LINE_W   write line from arbiter
//   line_o     out  LINE_W   assembled read line, valid while resp_o=1
//   resp_o     out  1        one-cycle completion pulse to arbiter
//   burst_i    in   BURST_W  read beat from pmem
//   burst_o    out  BURST_W  write beat to pmem
//   address_o  out  ADDR_W   line-aligned burst address to pmem
//   read_o     out  1        pmem burst read request
//   write_o    out  1        pmem burst write request
//   resp_i     in   1        pmem per-beat acknowledge
// ----------------------------------------------------------------------------
module pmem_burst_adaptor #(
    parameter int LINE_W  = rv32i_types::LINE_W,
    parameter int BURST_W = rv32i_types::BURST_W,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    import rv32i_types::*;

    // The beat count is derived from the two widths so the line is always
    // covered exactly; it is deliberately not a parameter of its own.
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = rv32i_types::LINE_OFFSET_BITS;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    pmem_burst_state_t  r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  r_buffer;

    logic               w_idleAccept;
    logic               w_lastBeat;
    logic               w_rdBeat;

    // A request is only looked at in IDLE. In DONE the arbiter is still
    // holding its request, so sampling there would start a duplicate burst.
    assign w_idleAccept = (r_state == IDLE) && (read_i || write_i);

    // The last beat is recognised on its acknowledge, which is also the edge
    // that moves the FSM to DONE and wraps the counter back to zero.
    assign w_lastBeat   = (r_cnt == LAST_BEAT);

    // A read beat is captured only while a read burst is actually running;
    // pmem acknowledges seen in IDLE or DONE carry no data for us.
    assign w_rdBeat     = (r_state == RD_BURST) && resp_i;

    // State and beat counter. Write has priority over read when both arrive
    // together. The counter is held at zero in IDLE so every burst starts at
    // beat 0, and it only advances on a pmem acknowledge, so stalls of any
    // length simply freeze it. Reset abandons whatever burst was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (write_i) begin
                        r_state <= WR_BURST;
                    end else if (read_i) begin
                        r_state <= RD_BURST;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (resp_i) begin
                        if (w_lastBeat) begin
                            r_cnt   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Datapath registers. The address is aligned as it is latched so the
    // pmem side never sees the arbiter's byte-offset bits. The write line is
    // captured only for writes. The read buffer is filled beat by beat, beat
    // 0 landing in the least significant slice, and is never cleared between
    // reads, so line_o keeps the last read line until a new read overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_line   <= '0;
            r_buffer <= '0;
        end else begin
            if (w_idleAccept) begin
                r_addr <= address_i & ADDR_MASK;
            end
            if ((r_state == IDLE) && write_i) begin
                r_line <= line_i;
            end
            if (w_rdBeat) begin
                r_buffer[int'(r_cnt) * BURST_W +: BURST_W] <= burst_i;
            end
        end
    end

    // Output decode depends on registers only, never on the request inputs,
    // so read_o/write_o stay steady for the whole burst even if the arbiter
    // drops its request, and every output falls as soon as rst_n is asserted.
    // burst_o is driven only during a write burst and is zero otherwise.
    always_comb begin
        read_o    = (r_state == RD_BURST);
        write_o   = (r_state == WR_BURST);
        resp_o    = (r_state == DONE);
        line_o    = r_buffer;
        address_o = r_addr;
        burst_o   = '0;
        if (r_state == WR_BURST) begin
            burst_o = r_line[int'(r_cnt) * BURST_W +: BURST_W];
        end
    end

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// ----------------------------------------------------------------------------
// Testbench: tb_pmem_burst_adaptor
//
// Purpose:
//   Self-checking bench for pmem_burst_adaptor. Acts as both the arbiter and
//   the pmem device. Each transaction's expectations come from a line-level
//   model: the read line is the concatenation of the beats the bench handed
//   out, the write beats are slices of the line the bench sent, the burst
//   ends after exactly four acknowledges, and the aligned address is the
//   request address with its low five bits cleared.
// ----------------------------------------------------------------------------
module tb_pmem_burst_adaptor;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                read_i = 1'b0;
    logic                write_i = 1'b0;
    logic [ADDR_W-1:0]   address_i = '0;
    logic [LINE_W-1:0]   line_i = '0;
    logic [LINE_W-1:0]   line_o;
    logic                resp_o;
    logic [BURST_W-1:0]  burst_i = '0;
    logic [BURST_W-1:0]  burst_o;
    logic [ADDR_W-1:0]   address_o;
    logic                read_o;
    logic                write_o;
    logic                resp_i = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [LINE_W-1:0] lastReadLine = '0;

    pmem_burst_adaptor #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[i*32 +: 32] = $urandom();
        end
        return l;
    endfunction

    // Runs one arbiter transaction against the pmem model. Entered and left
    // on a falling edge. ackPattern/patLen give a fixed acknowledge sequence
    // when patLen>0, otherwise acknowledges are random with stallPct percent
    // stalls. expRespCycle>0 also checks the cycle number of resp_o.
    task automatic run_txn(input bit doRead, input bit doWrite,
                           input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wline,
                           input bit fixedBeats, input int stallPct,
                           input logic [15:0] ackPattern, input int patLen,
                           input bit holdThroughDone, input bit spuriousDone,
                           input int expRespCycle);
        logic [BURST_W-1:0] beats [BEATS];
        logic [LINE_W-1:0]  expLine;
        logic [LINE_W-1:0]  ext;
        logic [ADDR_W-1:0]  expAddr;
        logic [BURST_W-1:0] expBeat;
        bit                 isWrite;
        bit                 ack;
        bit                 done;
        int                 acks;
        int                 cycle;
        int                 patIdx;

        isWrite = doWrite;
        acks    = 0;
        cycle   = 0;
        patIdx  = 0;
        done    = 1'b0;
        expAddr = addr & 32'hFFFF_FFE0;

        for (int k = 0; k < BEATS; k++) begin
            beats[k] = {$urandom(), $urandom()};
        end
        if (fixedBeats) begin
            beats[0] = 64'hAAAA_AAAA_AAAA_AAAA;
            beats[1] = 64'hBBBB_BBBB_BBBB_BBBB;
            beats[2] = 64'hCCCC_CCCC_CCCC_CCCC;
            beats[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        end
        expLine = '0;
        for (int k = 0; k < BEATS; k++) begin
            ext = '0;
            ext[BURST_W-1:0] = beats[k];
            expLine = expLine | (ext << (BURST_W * k));
        end

        read_i    = doRead;
        write_i   = doWrite;
        address_i = addr;
        line_i    = wline;
        resp_i    = 1'b0;

        while (!done && cycle < 200) begin
            @(negedge clk);
            cycle++;
            if (acks < BEATS) begin
                checks++;
                if (read_o !== !isWrite) begin
                    errors++;
                    $display("[TB] FAIL read_o cyc%0d: got %b expected %b", cycle, read_o, !isWrite);
                end
                checks++;
                if (write_o !== isWrite) begin
                    errors++;
                    $display("[TB] FAIL write_o cyc%0d: got %b expected %b", cycle, write_o, isWrite);
                end
                checks++;
                if (resp_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL early_resp cyc%0d: got %b expected 0", cycle, resp_o);
                end
                checks++;
                if (address_o !== expAddr) begin
                    errors++;
                    $display("[TB] FAIL address_o: got %h expected %h", address_o, expAddr);
                end
                if (isWrite) begin
                    expBeat = wline[acks*BURST_W +: BURST_W];
                    checks++;
                    if (burst_o !== expBeat) begin
                        errors++;
                        $display("[TB] FAIL burst_o beat%0d: got %h expected %h", acks, burst_o, expBeat);
                    end
                end
                if (patLen > 0) begin
                    ack = (patIdx < patLen) ? ackPattern[patIdx] : 1'b1;
                    patIdx++;
                end else begin
                    ack = ($urandom_range(0, 99) >= stallPct);
                end
                resp_i  = ack;
                burst_i = ack ? beats[acks] : {$urandom(), $urandom()};
                if (ack) begin
                    acks++;
                end
            end else begin
                checks++;
                if (resp_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL resp_o: got %b expected 1", resp_o);
                end
                checks++;
                if ((read_o | write_o) !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL done_req: got rd=%b wr=%b expected 0 0", read_o, write_o);
                end
                if (!isWrite) begin
                    checks++;
                    if (line_o !== expLine) begin
                        errors++;
                        $display("[TB] FAIL line_o: got %h expected %h", line_o, expLine);
                    end
                    lastReadLine = expLine;
                end
                if (expRespCycle > 0) begin
                    checks++;
                    if (cycle !== expRespCycle) begin
                        errors++;
                        $display("[TB] FAIL resp_cycle: got %0d expected %0d", cycle, expRespCycle);
                    end
                end
                resp_i  = spuriousDone;
                burst_i = {$urandom(), $urandom()};
                if (!holdThroughDone) begin
                    read_i  = 1'b0;
                    write_i = 1'b0;
                end
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: got no resp_o in %0d cycles expected resp_o", cycle);
        end

        // First cycle back in IDLE: no extra pulse, no new burst even if the
        // request was held through DONE, read line still visible.
        @(negedge clk);
        checks++;
        if ({resp_o, read_o, write_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL post_done: got resp/rd/wr=%b%b%b expected 000", resp_o, read_o, write_o);
        end
        checks++;
        if (line_o !== lastReadLine) begin
            errors++;
            $display("[TB] FAIL line_hold: got %h expected %h", line_o, lastReadLine);
        end
        resp_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_o, read_o, write_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b%b%b expected 000", resp_o, read_o, write_o);
        end
        checks++;
        if (line_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_line: got %h expected 0", line_o);
        end
        checks++;
        if (burst_o !== '0 || address_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got burst %h addr %h expected 0 0", burst_o, address_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_no_stall();
        run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b1, 0, 16'h0, 0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_write_stalls();
        run_txn(1'b0, 1'b1, 32'h0000_8F3C,
                256'h0123456789ABCDEF_FEDCBA9876543210_02468ACE13579BDF_FDB97531ECA86420,
                1'b0, 0, 16'h0059, 7, 1'b0, 1'b0, 8);
    endtask

    task automatic test_write_priority();
        run_txn(1'b1, 1'b1, $urandom(), randLine(), 1'b0, 30, 16'h0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 1'b0, $urandom(), '0, 1'b0, 0, 16'h0, 0, 1'b1, 1'b0, 5);
        run_txn(1'b0, 1'b1, $urandom(), randLine(), 1'b0, 20, 16'h0, 0, 1'b1, 1'b0, 0);
        run_txn(1'b1, 1'b0, $urandom(), '0, 1'b0, 0, 16'h0, 0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_reset_mid_burst();
        read_i    = 1'b1;
        address_i = $urandom();
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom(), $urandom()};
            @(negedge clk);
        end
        resp_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_o, read_o, write_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL async_reset_ctl: got %b%b%b expected 000", resp_o, read_o, write_o);
        end
        checks++;
        if (line_o !== '0 || address_o !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_data: got line %h addr %h expected 0 0", line_o, address_o);
        end
        lastReadLine = '0;
        read_i = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        resp_i  = 1'b1;
        burst_i = {$urandom(), $urandom()};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({resp_o, read_o, write_o} !== 3'b000 || line_o !== '0) begin
                errors++;
                $display("[TB] FAIL stray_beats: got %b%b%b line %h expected 000 line 0",
                         resp_o, read_o, write_o, line_o);
            end
        end
        resp_i = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 1'b0, $urandom(), '0, 1'b0, 0, 16'h0, 0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_spurious_resp();
        resp_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            burst_i = {$urandom(), $urandom()};
            @(negedge clk);
            checks++;
            if ({resp_o, read_o, write_o} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL idle_spurious: got %b%b%b expected 000", resp_o, read_o, write_o);
            end
        end
        resp_i = 1'b0;
        run_txn(1'b1, 1'b0, $urandom(), '0, 1'b0, 25, 16'h0, 0, 1'b0, 1'b1, 0);
        run_txn(1'b1, 1'b0, $urandom(), '0, 1'b0, 0, 16'h0, 0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_random();
        int kind;
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 2);
            run_txn(kind != 1, kind != 0, $urandom(), randLine(), 1'b0,
                    $urandom_range(0, 60), 16'h0, 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_read_no_stall();
        test_write_stalls();
        test_write_priority();
        test_back_to_back();
        test_reset_mid_burst();
        test_spurious_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
